avalon_s_arbiter: RTL and testbench
===================================

// Module: avalon_s_arbiter
// PURPOSE
// - Shares one Avalon-standard device port between NH Avalon-standard hosts.
// - Arbitration is round-robin. A grant is held until the granted transfer completes.
// - Sits between the host ports and a single device, for example a shared memory or peripheral
//   behind the crossbar, when address decode is not needed.
// - Register-based grant: one arbitration cycle per transfer. No pipelining; readdata is
//   returned in the same cycle that waitrequest is low.
// PARAMETERS
// - NH  2   number of hosts (>=2)
// - DW  32  data width (multiple of 8)
// - AW  32  address width
// PORTS
// - clk                     in   1            clock; all state is updated on the rising edge
// - rst_n                   in   1            asynchronous, active-low reset
// - hosts_avn_read          in   NH           per-host read request
// - hosts_avn_write         in   NH           per-host write request
// - hosts_avn_address       in   NH x AW      per-host address (packed [NH-1:0][AW-1:0])
// - hosts_avn_byte_enable   in   NH x DW/8    per-host byte enables
// - hosts_avn_writedata     in   NH x DW      per-host write data
// - hosts_avn_readdata      out  NH x DW      read data, broadcast to every host
// - hosts_avn_waitrequest   out  NH           per-host stall
// - device_avn_read         out  1            read to device
// - device_avn_write        out  1            write to device
// - device_avn_address      out  AW           address to device
// - device_avn_byte_enable  out  DW/8         byte enables to device
// - device_avn_writedata    out  DW           write data to device
// - device_avn_readdata     in   DW           read data from device
// - device_avn_waitrequest  in   1            device stall
// - host_grant              out  NH           one-hot grant register (debug/status)
// BEHAVIOUR
// - req[i] = hosts_avn_read[i] | hosts_avn_write[i]. A host never asserts read and write together.
// - State machine, 2 states:
//   - IDLE:  if |req, load grant = next RR winner, go to GRANT; otherwise stay.
//   - GRANT: done = req[g] & ~device_avn_waitrequest.
//     - If done, clear grant and go to IDLE.
//     - If ~req[g] (the host dropped its request), clear grant and go to IDLE.
//     - Otherwise hold.
// - Round-robin: search starts at the host after last_grant, wraps NH-1 -> 0, and picks the
//   first host with req set. last_grant is updated on every IDLE -> GRANT transition.
// - Device outputs:
//   - In GRANT, read/write/address/byte_enable/writedata are the signals of the granted host.
//   - In IDLE, all device outputs are 0.
// - hosts_avn_waitrequest[i] = ~(GRANT & grant[i] & ~device_avn_waitrequest).
//   - Every non-granted host, and every host in IDLE, sees 1.
// - hosts_avn_readdata[i] = device_avn_readdata for all i, combinationally.
//   - Readdata is valid only when that host's waitrequest is 0 on a read.
// - Latency:
//   - A request first seen in cycle N drives the device in cycle N+1.
//   - The earliest completion is cycle N+1.
//   - There is one IDLE bubble between consecutive transfers, so peak throughput is
//     1 transfer per 2 cycles.
// - Simultaneous requests are resolved by the RR pointer. Requests arriving during GRANT wait
//   until the next IDLE.
// - Reset values:
//   - state = IDLE, grant = 0, last_grant = one-hot bit NH-1, so host 0 wins first.
//   - All device outputs = 0; all hosts_avn_waitrequest = 1.
// - Reset mid-transfer: outputs drop immediately (asynchronous). The transfer is abandoned and
//   is not replayed.
// TESTING
// - Single read:
//   - Stimulus: host0 read addr 0x100 at cycle N; device waitrequest=0, readdata=0xDEADBEEF.
//   - Response: device_avn_read=1 with addr 0x100 at N+1; host0 waitrequest=0 and
//     readdata=0xDEADBEEF at N+1; host0 waitrequest=1 at N.
// - Contention:
//   - Stimulus: host0 and host1 both hold writes continuously (data 0xA0 / 0xB1).
//   - Response: device sees 0xA0, 0xB1, 0xA0, 0xB1, one write every 2 cycles.
// - Device stall:
//   - Stimulus: device waitrequest=1 for 3 GRANT cycles while host0 is granted and host1
//     is requesting.
//   - Response: grant stays host0 for 4 cycles; host1 waitrequest=1 throughout; host1 is
//     granted after the following IDLE.
// - Request drop:
//   - Stimulus: host0 deasserts read while granted and device waitrequest=1.
//   - Response: next cycle is IDLE, and device read/write=0.
// - Reset mid-transfer:
//   - Stimulus: rst_n=0 during GRANT(host1).
//   - Response: device outputs=0 and host_grant=0 without waiting for a clock edge; after
//     release with both hosts requesting, host0 is granted first.
// - Sparse round-robin:
//   - Stimulus: NH=4, only hosts 1 and 3 requesting.
//   - Response: grants alternate 1, 3, 1, 3; hosts 0 and 2 keep waitrequest=1.

Source files
------------

// File: rtl/avalon_s_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_s_arbiter
//
// Purpose:
//   Shares a single Avalon-MM device port among NH hosts using round-robin
//   arbitration. A grant is registered in IDLE and held in GRANT until the
//   granted host's transfer completes or the host withdraws its request.
//   Each transfer therefore costs one IDLE arbitration cycle plus one or more
//   GRANT cycles. There is no pipelining: readdata is taken in the same cycle
//   that waitrequest is low.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   hosts_avn_read/write        per-host request strobes          [NH]
//   hosts_avn_address           per-host address                  [NH][AW]
//   hosts_avn_byte_enable       per-host byte enables             [NH][DW/8]
//   hosts_avn_writedata         per-host write data               [NH][DW]
//   hosts_avn_readdata          device readdata copied to all     [NH][DW]
//   hosts_avn_waitrequest       per-host stall                    [NH]
//   device_avn_*                single device-side Avalon-MM port
//   host_grant                  one-hot grant register (status)   [NH]
// ---------------------------------------------------------------------------
module avalon_s_arbiter #(
  parameter int NH = 2,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic [NH-1:0]                  hosts_avn_read,
  input  logic [NH-1:0]                  hosts_avn_write,
  input  logic [NH-1:0][AW-1:0]          hosts_avn_address,
  input  logic [NH-1:0][DW/8-1:0]        hosts_avn_byte_enable,
  input  logic [NH-1:0][DW-1:0]          hosts_avn_writedata,
  output logic [NH-1:0][DW-1:0]          hosts_avn_readdata,
  output logic [NH-1:0]                  hosts_avn_waitrequest,

  output logic                           device_avn_read,
  output logic                           device_avn_write,
  output logic [AW-1:0]                  device_avn_address,
  output logic [DW/8-1:0]                device_avn_byte_enable,
  output logic [DW-1:0]                  device_avn_writedata,
  input  logic [DW-1:0]                  device_avn_readdata,
  input  logic                           device_avn_waitrequest,

  output logic [NH-1:0]                  host_grant
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [NH-1:0] ONE_NH       = NH'(1);
  // Host 0 wins the first arbitration after reset.
  localparam logic [NH-1:0] LAST_GRANT_RST = ONE_NH << (NH - 1);

  logic [0:0]    state_q, state_d;
  logic [NH-1:0] grant_q, grant_d;
  logic [NH-1:0] last_grant_q, last_grant_d;

  logic [NH-1:0] req;
  logic          in_grant;
  logic          req_granted;

  // Round-robin search terms
  logic [NH-1:0] higher_mask;
  logic [NH-1:0] req_hi;
  logic [NH-1:0] pick_hi;
  logic [NH-1:0] pick_all;
  logic [NH-1:0] rr_winner;

  assign req         = hosts_avn_read | hosts_avn_write;
  assign in_grant    = (state_q == ST_GRANT);
  assign req_granted = |(req & grant_q);

  // Hosts strictly above the last winner get first pick; if none of them is
  // requesting, the search wraps to the lowest requesting host. last_grant is
  // always one-hot, so (L-1)|L covers every position at or below it.
  always_comb begin
    higher_mask = ~((last_grant_q - ONE_NH) | last_grant_q);
    req_hi      = req & higher_mask;
    // x & -x isolates the lowest set bit.
    pick_hi     = req_hi & (~req_hi + ONE_NH);
    pick_all    = req & (~req + ONE_NH);
    rr_winner   = (|req_hi) ? pick_hi : pick_all;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d      = rr_winner;
          last_grant_d = rr_winner;
          state_d      = ST_GRANT;
        end
      end
      default: begin
        // Release on completion or when the owner withdraws its request;
        // completion implies the request is still present.
        if (!req_granted || !device_avn_waitrequest) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // AND-OR mux of the granted host onto the device port. The grant is
  // one-hot in GRANT and zero in IDLE, so the outputs are zero in IDLE and
  // drop together with the asynchronous reset.
  always_comb begin
    device_avn_read        = 1'b0;
    device_avn_write       = 1'b0;
    device_avn_address     = '0;
    device_avn_byte_enable = '0;
    device_avn_writedata   = '0;
    for (int i = 0; i < NH; i++) begin
      if (in_grant && grant_q[i]) begin
        device_avn_read        = device_avn_read        | hosts_avn_read[i];
        device_avn_write       = device_avn_write       | hosts_avn_write[i];
        device_avn_address     = device_avn_address     | hosts_avn_address[i];
        device_avn_byte_enable = device_avn_byte_enable | hosts_avn_byte_enable[i];
        device_avn_writedata   = device_avn_writedata   | hosts_avn_writedata[i];
      end
    end
  end

  always_comb begin
    hosts_avn_waitrequest = ~({NH{in_grant & ~device_avn_waitrequest}} & grant_q);
  end

  // Readdata goes to everyone; only the host seeing waitrequest low uses it.
  always_comb begin
    for (int i = 0; i < NH; i++) begin
      hosts_avn_readdata[i] = device_avn_readdata;
    end
  end

  assign host_grant = grant_q;

endmodule

// File: tb/tb_avalon_s_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_s_arbiter
//
// Directed bench: a table of per-cycle stimulus/expected records for a
// two-host arbiter, followed by hand-written sequences for reset during a
// transfer and sparse round-robin on a four-host arbiter.
// ---------------------------------------------------------------------------
module tb_avalon_s_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Two-host instance
  logic [1:0]        h_rd, h_wr, h_wait, grant;
  logic [1:0][31:0]  h_addr, h_wd, h_rdata;
  logic [1:0][3:0]   h_be;
  logic              d_rd, d_wr, d_wait;
  logic [31:0]       d_addr, d_wd, d_rdata;
  logic [3:0]        d_be;

  avalon_s_arbiter #(.NH(2), .DW(32), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .hosts_avn_read(h_rd), .hosts_avn_write(h_wr),
    .hosts_avn_address(h_addr), .hosts_avn_byte_enable(h_be),
    .hosts_avn_writedata(h_wd), .hosts_avn_readdata(h_rdata),
    .hosts_avn_waitrequest(h_wait),
    .device_avn_read(d_rd), .device_avn_write(d_wr),
    .device_avn_address(d_addr), .device_avn_byte_enable(d_be),
    .device_avn_writedata(d_wd), .device_avn_readdata(d_rdata),
    .device_avn_waitrequest(d_wait),
    .host_grant(grant)
  );

  // Four-host instance
  logic [3:0]        h4_rd, h4_wr, h4_wait, grant4;
  logic [3:0][31:0]  h4_addr, h4_wd, h4_rdata;
  logic [3:0][3:0]   h4_be;
  logic              d4_rd, d4_wr, d4_wait;
  logic [31:0]       d4_addr, d4_wd, d4_rdata;
  logic [3:0]        d4_be;

  avalon_s_arbiter #(.NH(4), .DW(32), .AW(32)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .hosts_avn_read(h4_rd), .hosts_avn_write(h4_wr),
    .hosts_avn_address(h4_addr), .hosts_avn_byte_enable(h4_be),
    .hosts_avn_writedata(h4_wd), .hosts_avn_readdata(h4_rdata),
    .hosts_avn_waitrequest(h4_wait),
    .device_avn_read(d4_rd), .device_avn_write(d4_wr),
    .device_avn_address(d4_addr), .device_avn_byte_enable(d4_be),
    .device_avn_writedata(d4_wd), .device_avn_readdata(d4_rdata),
    .device_avn_waitrequest(d4_wait),
    .host_grant(grant4)
  );

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1, d0, d1;
    logic        dw;
    logic [31:0] rdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic [1:0]  e_hw, e_g;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] rd, input logic [1:0] wr,
    input logic [31:0] a0, input logic [31:0] a1,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic dw, input logic [31:0] rdata,
    input logic e_rd, input logic e_wr,
    input logic [31:0] e_addr, input logic [31:0] e_wd, input logic [3:0] e_be,
    input logic [1:0] e_hw, input logic [1:0] e_g);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.dw = dw; v.rdata = rdata; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_be = e_be; v.e_hw = e_hw; v.e_g = e_g;
    return v;
  endfunction

  logic [3:0] exp_g4 [8];

  initial begin
    // host0 byte enables 0xF, host1 0x3 throughout
    // Contention: both hosts write continuously -> A0, B1, A0, B1
    vecs[0]  = mk(2'b00, 2'b00, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 0, 32'h0,  32'h0,  4'h0, 2'b11, 2'b00);
    vecs[1]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 0, 32'h0,  32'h0,  4'h0, 2'b11, 2'b00);
    vecs[2]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 1, 32'h10, 32'hA0, 4'hF, 2'b10, 2'b01);
    vecs[3]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 0, 32'h0,  32'h0,  4'h0, 2'b11, 2'b00);
    vecs[4]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 1, 32'h20, 32'hB1, 4'h3, 2'b01, 2'b10);
    vecs[5]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 0, 32'h0,  32'h0,  4'h0, 2'b11, 2'b00);
    vecs[6]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 1, 32'h10, 32'hA0, 4'hF, 2'b10, 2'b01);
    vecs[7]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 0, 32'h0,  32'h0,  4'h0, 2'b11, 2'b00);
    vecs[8]  = mk(2'b00, 2'b11, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 1, 32'h20, 32'hB1, 4'h3, 2'b01, 2'b10);
    vecs[9]  = mk(2'b00, 2'b00, 32'h10, 32'h20, 32'hA0, 32'hB1, 1'b0, 32'h0, 0, 0, 32'h0,  32'h0,  4'h0, 2'b11, 2'b00);
    // Single read from host0, device ready
    vecs[10] = mk(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0, 4'h0, 2'b11, 2'b00);
    vecs[11] = mk(2'b01, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0, 4'hF, 2'b10, 2'b01);
    vecs[12] = mk(2'b00, 2'b00, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0, 4'h0, 2'b11, 2'b00);
    // Device stall for three GRANT cycles, host1 waiting
    vecs[13] = mk(2'b01, 2'b00, 32'h200, 32'h300, 32'h0, 32'h55, 1'b1, 32'h12345678, 0, 0, 32'h0,   32'h0,  4'h0, 2'b11, 2'b00);
    vecs[14] = mk(2'b01, 2'b10, 32'h200, 32'h300, 32'h0, 32'h55, 1'b1, 32'h12345678, 1, 0, 32'h200, 32'h0,  4'hF, 2'b11, 2'b01);
    vecs[15] = mk(2'b01, 2'b10, 32'h200, 32'h300, 32'h0, 32'h55, 1'b1, 32'h12345678, 1, 0, 32'h200, 32'h0,  4'hF, 2'b11, 2'b01);
    vecs[16] = mk(2'b01, 2'b10, 32'h200, 32'h300, 32'h0, 32'h55, 1'b1, 32'h12345678, 1, 0, 32'h200, 32'h0,  4'hF, 2'b11, 2'b01);
    vecs[17] = mk(2'b01, 2'b10, 32'h200, 32'h300, 32'h0, 32'h55, 1'b0, 32'h12345678, 1, 0, 32'h200, 32'h0,  4'hF, 2'b10, 2'b01);
    vecs[18] = mk(2'b00, 2'b10, 32'h200, 32'h300, 32'h0, 32'h55, 1'b0, 32'h12345678, 0, 0, 32'h0,   32'h0,  4'h0, 2'b11, 2'b00);
    vecs[19] = mk(2'b00, 2'b10, 32'h200, 32'h300, 32'h0, 32'h55, 1'b0, 32'h12345678, 0, 1, 32'h300, 32'h55, 4'h3, 2'b01, 2'b10);
    vecs[20] = mk(2'b00, 2'b00, 32'h200, 32'h300, 32'h0, 32'h55, 1'b0, 32'h12345678, 0, 0, 32'h0,   32'h0,  4'h0, 2'b11, 2'b00);
    // Host0 drops its read while stalled
    vecs[21] = mk(2'b01, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 0, 0, 32'h0,   32'h0, 4'h0, 2'b11, 2'b00);
    vecs[22] = mk(2'b01, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 1, 0, 32'h400, 32'h0, 4'hF, 2'b11, 2'b01);
    vecs[23] = mk(2'b00, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 0, 0, 32'h400, 32'h0, 4'hF, 2'b11, 2'b01);
    vecs[24] = mk(2'b00, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 0, 0, 32'h0,   32'h0, 4'h0, 2'b11, 2'b00);

    exp_g4[0] = 4'b0000; exp_g4[1] = 4'b0010; exp_g4[2] = 4'b0000; exp_g4[3] = 4'b1000;
    exp_g4[4] = 4'b0000; exp_g4[5] = 4'b0010; exp_g4[6] = 4'b0000; exp_g4[7] = 4'b1000;

    h_rd = '0; h_wr = '0; h_addr = '0; h_wd = '0; d_wait = 1'b0; d_rdata = '0;
    h_be[0] = 4'hF; h_be[1] = 4'h3;
    h4_rd = '0; h4_wr = '0; h4_addr = '0; h4_wd = '0; h4_be = '0;
    d4_wait = 1'b0; d4_rdata = 32'hCAFE0000;

    // Reset state
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dev_rd",   {63'd0, d_rd}, 64'd0);
    chk("rst_dev_wr",   {63'd0, d_wr}, 64'd0);
    chk("rst_dev_addr", {32'd0, d_addr}, 64'd0);
    chk("rst_hw",       {62'd0, h_wait}, 64'd3);
    chk("rst_grant",    {62'd0, grant}, 64'd0);
    chk("rst_hw4",      {60'd0, h4_wait}, 64'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      h_rd = vecs[i].rd; h_wr = vecs[i].wr;
      h_addr[0] = vecs[i].a0; h_addr[1] = vecs[i].a1;
      h_wd[0] = vecs[i].d0; h_wd[1] = vecs[i].d1;
      d_wait = vecs[i].dw; d_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_dev_rd", i),   {63'd0, d_rd},   {63'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_dev_wr", i),   {63'd0, d_wr},   {63'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_dev_addr", i), {32'd0, d_addr}, {32'd0, vecs[i].e_addr});
      chk($sformatf("v%0d_dev_wd", i),   {32'd0, d_wd},   {32'd0, vecs[i].e_wd});
      chk($sformatf("v%0d_dev_be", i),   {60'd0, d_be},   {60'd0, vecs[i].e_be});
      chk($sformatf("v%0d_host_wait", i), {62'd0, h_wait}, {62'd0, vecs[i].e_hw});
      chk($sformatf("v%0d_grant", i),    {62'd0, grant},  {62'd0, vecs[i].e_g});
      chk($sformatf("v%0d_rdata", i),    {h_rdata[1], h_rdata[0]}, {vecs[i].rdata, vecs[i].rdata});
    end

    // Reset in the middle of a host1 transfer (last winner was host0)
    @(posedge clk);
    #1;
    h_rd = 2'b00; h_wr = 2'b10; h_addr[1] = 32'h500; h_wd[1] = 32'h77; d_wait = 1'b1;
    @(negedge clk);
    chk("mr_idle_grant", {62'd0, grant}, 64'd0);
    @(negedge clk);
    chk("mr_grant_h1", {62'd0, grant}, 64'd2);
    chk("mr_dev_wr",   {63'd0, d_wr}, 64'd1);
    chk("mr_dev_addr", {32'd0, d_addr}, 64'h500);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_wr",    {63'd0, d_wr}, 64'd0);
    chk("mr_async_addr",  {32'd0, d_addr}, 64'd0);
    chk("mr_async_wd",    {32'd0, d_wd}, 64'd0);
    chk("mr_async_grant", {62'd0, grant}, 64'd0);
    chk("mr_async_hw",    {62'd0, h_wait}, 64'd3);
    h_wr = 2'b11; h_wd[0] = 32'h66; h_addr[0] = 32'h600; d_wait = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_post_grant", {62'd0, grant}, 64'd1);
    chk("mr_post_wd",    {32'd0, d_wd}, 64'h66);
    @(posedge clk);
    #1;
    h_wr = 2'b00;

    // Sparse round-robin on four hosts: only 1 and 3 request
    h4_addr[1] = 32'h1000; h4_addr[3] = 32'h3000;
    h4_wd[1]   = 32'h11;   h4_wd[3]   = 32'h33;
    h4_be[1]   = 4'h1;     h4_be[3]   = 4'h8;
    h4_wr      = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rr4_c%0d_grant", c), {60'd0, grant4}, {60'd0, exp_g4[c]});
      chk($sformatf("rr4_c%0d_hw02", c), {62'd0, h4_wait[2], h4_wait[0]}, 64'd3);
      chk($sformatf("rr4_c%0d_wd", c), {32'd0, d4_wd},
          (exp_g4[c] == 4'b0010) ? 64'h11 : (exp_g4[c] == 4'b1000) ? 64'h33 : 64'h0);
      chk($sformatf("rr4_c%0d_hw13", c), {62'd0, h4_wait[3], h4_wait[1]},
          {62'd0, ~exp_g4[c][3], ~exp_g4[c][1]});
    end
    chk("rr4_rdata", {32'd0, h4_rdata[2]}, 64'hCAFE0000);
    h4_wr = '0;
    chk("rr4_dev_be", {60'd0, d4_be}, 64'h8);
    chk("rr4_dev_rd", {63'd0, d4_rd}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
